ram_banked: RTL



---
 rtl/ram_pkg.sv | 31 +++
 rtl/ram_bank.sv | 27 ++
 rtl/ram_banked.sv | 102 ++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the banked word RAM.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2_ge2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int unsigned width,
                                        input int unsigned banks,
                                        input int unsigned depth);
        return (width >= 1) && is_pow2_ge2(banks) && is_pow2_ge2(depth);
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One WIDTH x DEPTH storage bank: synchronous write, combinational read.
module ram_bank
    import ram_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned WAW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WAW-1:0]   addr,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage carries no reset; the top-level clear sequencer zero-fills it.
    always_ff @(posedge clk) begin
        if (load) begin
            mem[addr] <= data;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/ram_banked.sv
// Banked word RAM with valid/ready request port, registered read response
// and a zero-fill sequencer that runs after reset and on clear_start.
module ram_banked
    import ram_pkg::*;
#(
    parameter  int unsigned WIDTH      = 16,
    parameter  int unsigned BANKS      = 8,
    parameter  int unsigned BANK_DEPTH = 8,
    localparam int unsigned AW         = clog2(BANKS * BANK_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             clear_start,
    output logic             busy
);

    localparam int unsigned WAW = clog2(BANK_DEPTH);
    localparam int unsigned BAW = clog2(BANKS);

    if (!params_legal(WIDTH, BANKS, BANK_DEPTH)) begin : g_param_check
        $error("ram_banked: BANKS and BANK_DEPTH must be powers of two >= 2");
    end

    state_t           state;
    logic [WAW-1:0]   clr_idx;

    logic             clearing_c;
    logic             wr_acc_c;
    logic             rd_acc_c;
    logic [BAW-1:0]   bank_idx_c;
    logic [WAW-1:0]   word_c;
    logic [BANKS-1:0] bank_sel_c;
    logic [WAW-1:0]   bank_addr_c;
    logic [WIDTH-1:0] bank_wdata_c;
    logic [WIDTH-1:0] bank_rdata_c [BANKS];

    assign clearing_c   = (state == ST_CLEAR);
    assign wr_acc_c     = req_valid & req_ready & req_we;
    assign rd_acc_c     = req_valid & req_ready & ~req_we;
    assign bank_idx_c   = req_addr[AW-1:WAW];
    assign word_c       = req_addr[WAW-1:0];
    assign bank_sel_c   = BANKS'(1) << bank_idx_c;

    // Clear traffic shares the bank write port with normal requests.
    assign bank_addr_c  = clearing_c ? clr_idx : word_c;
    assign bank_wdata_c = clearing_c ? '0 : req_wdata;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ram_bank #(
            .WIDTH (WIDTH),
            .DEPTH (BANK_DEPTH)
        ) u_bank (
            .clk     (clk),
            .load    (clearing_c | (wr_acc_c & bank_sel_c[b])),
            .addr    (bank_addr_c),
            .data    (bank_wdata_c),
            .rdata_c (bank_rdata_c[b])
        );
    end

    // Sequencer and response registers; req_ready/busy track state only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == ST_CLEAR) begin
                clr_idx <= clr_idx + WAW'(1);
                if (clr_idx == WAW'(BANK_DEPTH - 1)) begin
                    state     <= ST_IDLE;
                    clr_idx   <= '0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            end else begin
                if (rd_acc_c) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= bank_rdata_c[bank_idx_c];
                end
                if (clear_start) begin
                    state     <= ST_CLEAR;
                    clr_idx   <= '0;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                end
            end
        end
    end

endmodule
